decode_stage_hz: RTL and testbench

// Parametrised successor decode-stage pipeline register. It accepts a decoded instruction (packed control bundle

---
 rtl/decode_stage_hz.sv | 124 ++++++++++++
 tb/tb_decode_stage_hz.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_hz.sv
// Decode-stage pipeline register with valid/ready handshake, EX/WB operand forwarding,
// load-use interlock, branch flush and a saturating hazard-stall counter.
module decode_stage_hz #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RADDR_W  = 5,
    parameter int unsigned CTRL_W   = 64,
    parameter int unsigned FWD_EN   = 1,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [RADDR_W-1:0] in_addr_ra,
    input  logic [RADDR_W-1:0] in_addr_rb,
    input  logic [RADDR_W-1:0] in_addr_rc,
    input  logic               in_use_ra,
    input  logic               in_use_rb,
    input  logic               in_use_rc,
    input  logic [DATA_W-1:0]  in_data_ra,
    input  logic [DATA_W-1:0]  in_data_rb,
    input  logic [DATA_W-1:0]  in_data_rc,
    input  logic               ex_we,
    input  logic [RADDR_W-1:0] ex_addr_rd,
    input  logic               ex_res_vld,
    input  logic [DATA_W-1:0]  ex_res,
    input  logic               wb_we,
    input  logic [RADDR_W-1:0] wb_addr_rd,
    input  logic [DATA_W-1:0]  wb_res,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [DATA_W-1:0]  out_data_a,
    output logic [DATA_W-1:0]  out_data_b,
    output logic [DATA_W-1:0]  out_data_c,
    output logic [CNT_W-1:0]   stall_cnt
);

    typedef enum logic {EMPTY, FULL} slot_t;

    slot_t              state, state_nxt;
    logic [RADDR_W-1:0] src_addr [3];
    logic               src_use  [3];
    logic [DATA_W-1:0]  src_data [3];
    logic [DATA_W-1:0]  fwd_data [3];
    logic               src_zero [3];
    logic               ex_hit   [3];
    logic [2:0]         haz;
    logic               hazard;
    logic               slot_free;
    logic               accept;
    logic               count_stall;

    always_comb begin
        src_addr = '{in_addr_ra, in_addr_rb, in_addr_rc};
        src_use  = '{in_use_ra, in_use_rb, in_use_rc};
        src_data = '{in_data_ra, in_data_rb, in_data_rc};
        haz      = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            src_zero[i] = (ZERO_REG != 0) && (src_addr[i] == '0);
            ex_hit[i]   = ex_we && (ex_addr_rd == src_addr[i]) && !src_zero[i];
            haz[i]      = src_use[i] && ex_hit[i] && (!ex_res_vld || (FWD_EN == 0));
            // EX forwarding only with a ready result; WB forwarding stays on even when FWD_EN=0
            if (src_zero[i])
                fwd_data[i] = '0;
            else if (ex_hit[i] && ex_res_vld && (FWD_EN != 0))
                fwd_data[i] = ex_res;
            else if (wb_we && (wb_addr_rd == src_addr[i]))
                fwd_data[i] = wb_res;
            else
                fwd_data[i] = src_data[i];
        end
    end

    assign hazard      = |haz;
    assign out_valid   = (state == FULL);
    assign slot_free   = !out_valid || out_ready;
    assign in_ready    = !hazard && !flush && slot_free;
    assign accept      = in_valid && in_ready;
    assign count_stall = in_valid && hazard && slot_free && !flush;

    always_ff @(posedge clk) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = EMPTY;
        else if (accept)
            state_nxt = FULL;
        else if (slot_free)
            state_nxt = EMPTY;
    end

    // Payload only moves on accept, so a held slot is never re-forwarded
    always_ff @(posedge clk) begin
        if (rst) begin
            out_ctrl   <= '0;
            out_data_a <= '0;
            out_data_b <= '0;
            out_data_c <= '0;
        end else if (accept) begin
            out_ctrl   <= in_ctrl;
            out_data_a <= fwd_data[0];
            out_data_b <= fwd_data[1];
            out_data_c <= fwd_data[2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (count_stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed self-checking bench for decode_stage_hz; a second instance (CNT_W=2, FWD_EN=0)
// covers counter saturation and the EX-forwarding-disabled mode.
module tb_decode_stage_hz;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_ctrl;
    logic [4:0]  in_addr_ra, in_addr_rb, in_addr_rc;
    logic        in_use_ra, in_use_rb, in_use_rc;
    logic [31:0] in_data_ra, in_data_rb, in_data_rc;
    logic        ex_we;
    logic [4:0]  ex_addr_rd;
    logic        ex_res_vld;
    logic [31:0] ex_res;
    logic        wb_we;
    logic [4:0]  wb_addr_rd;
    logic [31:0] wb_res;
    logic        flush;
    logic        out_ready;

    logic        in_ready, out_valid;
    logic [63:0] out_ctrl;
    logic [31:0] out_data_a, out_data_b, out_data_c;
    logic [15:0] stall_cnt;

    logic        in_ready2, out_valid2;
    logic [63:0] out_ctrl2;
    logic [31:0] out_data_a2, out_data_b2, out_data_c2;
    logic [1:0]  stall_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage_hz dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_addr_ra(in_addr_ra), .in_addr_rb(in_addr_rb), .in_addr_rc(in_addr_rc),
        .in_use_ra(in_use_ra), .in_use_rb(in_use_rb), .in_use_rc(in_use_rc),
        .in_data_ra(in_data_ra), .in_data_rb(in_data_rb), .in_data_rc(in_data_rc),
        .ex_we(ex_we), .ex_addr_rd(ex_addr_rd), .ex_res_vld(ex_res_vld), .ex_res(ex_res),
        .wb_we(wb_we), .wb_addr_rd(wb_addr_rd), .wb_res(wb_res), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data_a(out_data_a), .out_data_b(out_data_b), .out_data_c(out_data_c),
        .stall_cnt(stall_cnt)
    );

    decode_stage_hz #(.CNT_W(2), .FWD_EN(0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_ctrl(in_ctrl),
        .in_addr_ra(in_addr_ra), .in_addr_rb(in_addr_rb), .in_addr_rc(in_addr_rc),
        .in_use_ra(in_use_ra), .in_use_rb(in_use_rb), .in_use_rc(in_use_rc),
        .in_data_ra(in_data_ra), .in_data_rb(in_data_rb), .in_data_rc(in_data_rc),
        .ex_we(ex_we), .ex_addr_rd(ex_addr_rd), .ex_res_vld(ex_res_vld), .ex_res(ex_res),
        .wb_we(wb_we), .wb_addr_rd(wb_addr_rd), .wb_res(wb_res), .flush(flush),
        .out_valid(out_valid2), .out_ready(out_ready), .out_ctrl(out_ctrl2),
        .out_data_a(out_data_a2), .out_data_b(out_data_b2), .out_data_c(out_data_c2),
        .stall_cnt(stall_cnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_ctrl = '0;
        in_addr_ra = 0; in_addr_rb = 0; in_addr_rc = 0;
        in_use_ra = 0; in_use_rb = 0; in_use_rc = 0;
        in_data_ra = 0; in_data_rb = 0; in_data_rc = 0;
        ex_we = 0; ex_addr_rd = 0; ex_res_vld = 0; ex_res = 0;
        wb_we = 0; wb_addr_rd = 0; wb_res = 0;
        flush = 0; out_ready = 1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (out_ctrl !== 64'h0) begin errors++; $display("FAIL reset_ctrl got %0h want 0", out_ctrl); end
        checks++; if ({out_data_a, out_data_b, out_data_c} !== 96'h0) begin errors++; $display("FAIL reset_data got %0h want 0", {out_data_a, out_data_b, out_data_c}); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
        checks++; if (stall_cnt2 !== 2'd0) begin errors++; $display("FAIL reset_cnt2 got %0d want 0", stall_cnt2); end
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_basic();
        do_reset();
        in_valid = 1; in_ctrl = 64'hA5;
        in_addr_ra = 3; in_use_ra = 1; in_data_ra = 32'd7;
        in_addr_rb = 5; in_use_rb = 1; in_data_rb = 32'd9;
        in_addr_rc = 6; in_use_rc = 1; in_data_rc = 32'h33;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %0b want 1", in_ready); end
        step();
        idle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b want 1", out_valid); end
        checks++; if (out_ctrl !== 64'hA5) begin errors++; $display("FAIL basic_ctrl got %0h want a5", out_ctrl); end
        checks++; if (out_data_a !== 32'd7) begin errors++; $display("FAIL basic_a got %0h want 7", out_data_a); end
        checks++; if (out_data_b !== 32'd9) begin errors++; $display("FAIL basic_b got %0h want 9", out_data_b); end
        checks++; if (out_data_c !== 32'h33) begin errors++; $display("FAIL basic_c got %0h want 33", out_data_c); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_back_to_back_fwd();
        do_reset();
        in_valid = 1; in_ctrl = 64'h1;
        ex_we = 1; ex_addr_rd = 3; ex_res_vld = 1; ex_res = 32'h11;
        wb_we = 1; wb_addr_rd = 3; wb_res = 32'h22;
        in_addr_ra = 3; in_use_ra = 1; in_data_ra = 32'h7;
        in_addr_rb = 3; in_use_rb = 0; in_data_rb = 32'h8;
        in_addr_rc = 9; in_use_rc = 1; in_data_rc = 32'h44;
        step();
        checks++; if (out_data_a !== 32'h11) begin errors++; $display("FAIL fwd_ex_wins got %0h want 11", out_data_a); end
        checks++; if (out_data_b !== 32'h11) begin errors++; $display("FAIL fwd_unused_b got %0h want 11", out_data_b); end
        checks++; if (out_data_c !== 32'h44) begin errors++; $display("FAIL fwd_nomatch_c got %0h want 44", out_data_c); end
        in_ctrl = 64'h2; ex_we = 0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %0b want 1", in_ready); end
        step();
        checks++; if (out_ctrl !== 64'h2) begin errors++; $display("FAIL b2b_ctrl got %0h want 2", out_ctrl); end
        checks++; if (out_data_a !== 32'h22) begin errors++; $display("FAIL fwd_wb got %0h want 22", out_data_a); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %0b want 1", out_valid); end
        idle();
        step();
    endtask

    task automatic test_load_use();
        do_reset();
        in_valid = 1; in_ctrl = 64'h3C;
        ex_we = 1; ex_addr_rd = 4; ex_res_vld = 0; ex_res = 32'h66;
        in_addr_rb = 4; in_use_rb = 1; in_data_rb = 32'h55;
        for (int i = 1; i <= 2; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_ready%0d got %0b want 0", i, in_ready); end
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_valid%0d got %0b want 0", i, out_valid); end
            checks++; if (stall_cnt !== 16'(i)) begin errors++; $display("FAIL lu_cnt%0d got %0d want %0d", i, stall_cnt, i); end
        end
        ex_res_vld = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_release got %0b want 1", in_ready); end
        step();
        idle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lu_accept got %0b want 1", out_valid); end
        checks++; if (out_data_b !== 32'h66) begin errors++; $display("FAIL lu_data got %0h want 66", out_data_b); end
        checks++; if (out_ctrl !== 64'h3C) begin errors++; $display("FAIL lu_ctrl got %0h want 3c", out_ctrl); end
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL lu_cnt_final got %0d want 2", stall_cnt); end
        step();
    endtask

    task automatic test_zero_reg();
        do_reset();
        in_valid = 1; in_ctrl = 64'h5;
        in_addr_ra = 0; in_use_ra = 1; in_data_ra = 32'h99;
        ex_we = 1; ex_addr_rd = 0; ex_res_vld = 0; ex_res = 32'h88;
        wb_we = 1; wb_addr_rd = 0; wb_res = 32'h77;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zr_ready got %0b want 1", in_ready); end
        step();
        idle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zr_valid got %0b want 1", out_valid); end
        checks++; if (out_data_a !== 32'h0) begin errors++; $display("FAIL zr_data got %0h want 0", out_data_a); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL zr_cnt got %0d want 0", stall_cnt); end
        step();
    endtask

    task automatic test_hold();
        do_reset();
        in_valid = 1; in_ctrl = 64'h12;
        in_addr_ra = 1; in_use_ra = 1; in_data_ra = 32'h10;
        step();
        out_ready = 0; in_ctrl = 64'h34; in_data_ra = 32'h20;
        ex_we = 1; ex_addr_rd = 2; ex_res_vld = 0;
        in_addr_rb = 2; in_use_rb = 1;
        wb_we = 1; wb_addr_rd = 1; wb_res = 32'hEE;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready%0d got %0b want 0", i, in_ready); end
            step();
            checks++; if (out_valid !== 1'b1 || out_ctrl !== 64'h12 || out_data_a !== 32'h10)
                begin errors++; $display("FAIL hold_stable%0d got v=%0b c=%0h a=%0h want v=1 c=12 a=10", i, out_valid, out_ctrl, out_data_a); end
            checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL hold_cnt%0d got %0d want 0", i, stall_cnt); end
        end
        out_ready = 1; ex_we = 0;
        step();
        idle();
        checks++; if (out_ctrl !== 64'h34 || out_data_a !== 32'hEE)
            begin errors++; $display("FAIL hold_release got c=%0h a=%0h want c=34 a=ee", out_ctrl, out_data_a); end
        step();
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1; in_ctrl = 64'h56;
        step();
        in_ctrl = 64'h78; flush = 1; out_ready = 0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %0b want 0", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", out_valid); end
        checks++; if (out_ctrl !== 64'h56) begin errors++; $display("FAIL flush_noaccept got %0h want 56", out_ctrl); end
        // flush together with a load-use hazard on a free slot must not count
        ex_we = 1; ex_addr_rd = 4; ex_res_vld = 0;
        in_addr_rb = 4; in_use_rb = 1; out_ready = 1;
        step();
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL flush_cnt got %0d want 0", stall_cnt); end
        idle();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_after got %0b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1; in_ctrl = 64'h9A; in_data_ra = 32'h5; in_addr_ra = 7;
        step();
        rst = 1; in_ctrl = 64'hBC; out_ready = 0;
        step();
        rst = 0;
        idle();
        checks++; if (out_valid !== 1'b0 || out_ctrl !== 64'h0)
            begin errors++; $display("FAIL reset_mid got v=%0b c=%0h want v=0 c=0", out_valid, out_ctrl); end
    endtask

    task automatic test_saturate();
        do_reset();
        in_valid = 1;
        ex_we = 1; ex_addr_rd = 4; ex_res_vld = 0;
        in_addr_rb = 4; in_use_rb = 1;
        for (int i = 1; i <= 5; i++) step();
        checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL sat_cnt16 got %0d want 5", stall_cnt); end
        checks++; if (stall_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_cnt2 got %0d want 3", stall_cnt2); end
        idle();
        step();
    endtask

    task automatic test_fwd_disabled();
        do_reset();
        in_valid = 1; in_ctrl = 64'h44;
        ex_we = 1; ex_addr_rd = 3; ex_res_vld = 1; ex_res = 32'h11;
        in_addr_ra = 3; in_use_ra = 1; in_data_ra = 32'h7;
        #1;
        checks++; if (in_ready !== 1'b1 || in_ready2 !== 1'b0)
            begin errors++; $display("FAIL nofwd_ready got fwd=%0b nofwd=%0b want 1/0", in_ready, in_ready2); end
        step();
        ex_we = 0; wb_we = 1; wb_addr_rd = 3; wb_res = 32'h22;
        #1;
        checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL nofwd_release got %0b want 1", in_ready2); end
        step();
        idle();
        checks++; if (out_valid2 !== 1'b1 || out_data_a2 !== 32'h22)
            begin errors++; $display("FAIL nofwd_wb got v=%0b a=%0h want v=1 a=22", out_valid2, out_data_a2); end
        step();
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_basic();
        test_back_to_back_fwd();
        test_load_use();
        test_zero_reg();
        test_hold();
        test_flush();
        test_reset_mid();
        test_saturate();
        test_fwd_disabled();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
